// File: rtl/result_pipeline.sv
// Result pipeline ST3..ST7 with late-completion capture and registered writeback.
// Entries age one stage per edge; the oldest entry at latency 1 takes compResult.
module result_pipeline (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issueValid,
    input  logic [6:0]   issueRT,
    input  logic         issueWE,
    input  logic [2:0]   issueLatency,
    input  logic [127:0] issueResult,
    input  logic         compValid,
    input  logic [127:0] compResult,
    input  logic         flush,
    output logic [6:0]   readRegisterRT_ST3,
    output logic [6:0]   readRegisterRT_ST4,
    output logic [6:0]   readRegisterRT_ST5,
    output logic [6:0]   readRegisterRT_ST6,
    output logic [6:0]   readRegisterRT_ST7,
    output logic         regWriteEnable_ST3,
    output logic         regWriteEnable_ST4,
    output logic         regWriteEnable_ST5,
    output logic         regWriteEnable_ST6,
    output logic         regWriteEnable_ST7,
    output logic [2:0]   latency_ST3,
    output logic [2:0]   latency_ST4,
    output logic [2:0]   latency_ST5,
    output logic [2:0]   latency_ST6,
    output logic [2:0]   latency_ST7,
    output logic [127:0] result_ST3,
    output logic [127:0] result_ST4,
    output logic [127:0] result_ST5,
    output logic [127:0] result_ST6,
    output logic [127:0] result_ST7,
    output logic         wbValid,
    output logic [6:0]   wbRT,
    output logic [127:0] wbResult,
    output logic [3:0]   errFlags,
    output logic [15:0]  retireCount
);

    typedef struct packed {
        logic [6:0]   rt;
        logic         we;
        logic [2:0]   lat;
        logic [127:0] res;
    } entry_t;

    // index 0 is ST3, index 4 is ST7
    entry_t         st_q [5];
    entry_t         st_d [5];
    logic           wb_valid_q, wb_valid_d;
    logic [6:0]     wb_rt_q, wb_rt_d;
    logic [127:0]   wb_res_q, wb_res_d;
    logic [3:0]     err_q, err_d;
    logic [15:0]    retire_q, retire_d;

    logic [127:0]   cap [4];
    logic [2:0]     hits;
    logic           taken;
    logic           load;
    logic           bad;

    always_comb begin
        hits  = '0;
        taken = 1'b0;
        // walk oldest to youngest so only the oldest match takes the data
        for (int i = 3; i >= 0; i--) begin
            cap[i] = '0;
            if (st_q[i].lat == 3'd1) begin
                hits = hits + 3'd1;
                if (!taken && compValid) cap[i] = compResult;
                taken = 1'b1;
            end
        end

        load  = issueValid && !flush;
        bad   = load && (issueLatency > 3'd4);
        st_d[0] = '0;
        if (load) begin
            st_d[0].rt  = issueRT;
            st_d[0].we  = issueWE;
            st_d[0].lat = bad ? 3'd4 : issueLatency;
            st_d[0].res = (issueLatency == 3'd0) ? issueResult : '0;
        end

        for (int i = 1; i < 5; i++) begin
            st_d[i] = st_q[i-1];
            if (st_q[i-1].lat != 3'd0) st_d[i].lat = st_q[i-1].lat - 3'd1;
            if (st_q[i-1].lat == 3'd1) st_d[i].res = cap[i-1];
            if (flush && i <= 2) st_d[i].we = 1'b0;
        end

        wb_valid_d = st_q[4].we;
        wb_rt_d    = st_q[4].we ? st_q[4].rt : '0;
        wb_res_d   = st_q[4].we ? st_q[4].res : '0;
        retire_d   = retire_q + {15'd0, st_q[4].we};

        err_d = err_q | {bad,
                         hits > 3'd1,
                         compValid && (hits == 3'd0),
                         !compValid && (hits != 3'd0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) st_q[i] <= '0;
            wb_valid_q <= 1'b0;
            wb_rt_q    <= '0;
            wb_res_q   <= '0;
            err_q      <= '0;
            retire_q   <= '0;
        end else begin
            for (int i = 0; i < 5; i++) st_q[i] <= st_d[i];
            wb_valid_q <= wb_valid_d;
            wb_rt_q    <= wb_rt_d;
            wb_res_q   <= wb_res_d;
            err_q      <= err_d;
            retire_q   <= retire_d;
        end
    end

    assign readRegisterRT_ST3 = st_q[0].rt;
    assign readRegisterRT_ST4 = st_q[1].rt;
    assign readRegisterRT_ST5 = st_q[2].rt;
    assign readRegisterRT_ST6 = st_q[3].rt;
    assign readRegisterRT_ST7 = st_q[4].rt;
    assign regWriteEnable_ST3 = st_q[0].we;
    assign regWriteEnable_ST4 = st_q[1].we;
    assign regWriteEnable_ST5 = st_q[2].we;
    assign regWriteEnable_ST6 = st_q[3].we;
    assign regWriteEnable_ST7 = st_q[4].we;
    assign latency_ST3        = st_q[0].lat;
    assign latency_ST4        = st_q[1].lat;
    assign latency_ST5        = st_q[2].lat;
    assign latency_ST6        = st_q[3].lat;
    assign latency_ST7        = st_q[4].lat;
    assign result_ST3         = st_q[0].res;
    assign result_ST4         = st_q[1].res;
    assign result_ST5         = st_q[2].res;
    assign result_ST6         = st_q[3].res;
    assign result_ST7         = st_q[4].res;
    assign wbValid            = wb_valid_q;
    assign wbRT               = wb_rt_q;
    assign wbResult           = wb_res_q;
    assign errFlags           = err_q;
    assign retireCount        = retire_q;

endmodule

// File: tb/tb_result_pipeline.sv
// Bench for result_pipeline: instruction-level reference model plus writeback scoreboard.
// Directed scenarios first, then randomized issue/complete/flush traffic.
module tb_result_pipeline;

    logic         clk;
    logic         rst_n;
    logic         issueValid;
    logic [6:0]   issueRT;
    logic         issueWE;
    logic [2:0]   issueLatency;
    logic [127:0] issueResult;
    logic         compValid;
    logic [127:0] compResult;
    logic         flush;
    logic [6:0]   rt3, rt4, rt5, rt6, rt7;
    logic         we3, we4, we5, we6, we7;
    logic [2:0]   lt3, lt4, lt5, lt6, lt7;
    logic [127:0] rs3, rs4, rs5, rs6, rs7;
    logic         wbValid;
    logic [6:0]   wbRT;
    logic [127:0] wbResult;
    logic [3:0]   errFlags;
    logic [15:0]  retireCount;

    result_pipeline dut (
        .clk(clk), .rst_n(rst_n),
        .issueValid(issueValid), .issueRT(issueRT), .issueWE(issueWE),
        .issueLatency(issueLatency), .issueResult(issueResult),
        .compValid(compValid), .compResult(compResult), .flush(flush),
        .readRegisterRT_ST3(rt3), .readRegisterRT_ST4(rt4),
        .readRegisterRT_ST5(rt5), .readRegisterRT_ST6(rt6),
        .readRegisterRT_ST7(rt7),
        .regWriteEnable_ST3(we3), .regWriteEnable_ST4(we4),
        .regWriteEnable_ST5(we5), .regWriteEnable_ST6(we6),
        .regWriteEnable_ST7(we7),
        .latency_ST3(lt3), .latency_ST4(lt4), .latency_ST5(lt5),
        .latency_ST6(lt6), .latency_ST7(lt7),
        .result_ST3(rs3), .result_ST4(rs4), .result_ST5(rs5),
        .result_ST6(rs6), .result_ST7(rs7),
        .wbValid(wbValid), .wbRT(wbRT), .wbResult(wbResult),
        .errFlags(errFlags), .retireCount(retireCount)
    );

    logic [6:0]   d_rt  [5];
    logic         d_we  [5];
    logic [2:0]   d_lat [5];
    logic [127:0] d_res [5];
    assign d_rt[0] = rt3;  assign d_rt[1] = rt4;  assign d_rt[2] = rt5;
    assign d_rt[3] = rt6;  assign d_rt[4] = rt7;
    assign d_we[0] = we3;  assign d_we[1] = we4;  assign d_we[2] = we5;
    assign d_we[3] = we6;  assign d_we[4] = we7;
    assign d_lat[0] = lt3; assign d_lat[1] = lt4; assign d_lat[2] = lt5;
    assign d_lat[3] = lt6; assign d_lat[4] = lt7;
    assign d_res[0] = rs3; assign d_res[1] = rs4; assign d_res[2] = rs5;
    assign d_res[3] = rs6; assign d_res[4] = rs7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Instruction-level model: each in-flight instruction knows its age.
    typedef struct {
        logic [6:0]   rt;
        logic         we;
        int           lat;
        logic [127:0] res;
        int           stg;
    } rec_t;
    typedef struct {
        logic [6:0]   rt;
        logic [127:0] res;
    } wb_t;

    rec_t        pipe [$];
    wb_t         exp_q [$];
    logic [3:0]  m_err;
    logic [15:0] m_ret;

    function automatic bit has_hit();
        foreach (pipe[i]) if (pipe[i].lat == 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        int   hits;
        bit   first;
        rec_t r;
        wb_t  w;
        hits  = 0;
        first = 1'b1;
        foreach (pipe[i]) if (pipe[i].lat == 1) hits++;
        if (compValid && hits == 0) m_err[1] = 1'b1;
        if (hits >= 2) m_err[2] = 1'b1;
        if (hits > 0 && !compValid) m_err[0] = 1'b1;
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].lat == 1) begin
                pipe[i].res = (first && compValid) ? compResult : '0;
                first = 1'b0;
            end
            if (pipe[i].lat > 0) pipe[i].lat--;
            if (flush && pipe[i].stg <= 1) pipe[i].we = 1'b0;
            pipe[i].stg++;
        end
        if (pipe.size() > 0 && pipe[0].stg == 5) begin
            r = pipe.pop_front();
            if (r.we) begin
                w.rt  = r.rt;
                w.res = r.res;
                exp_q.push_back(w);
                m_ret++;
            end
        end
        if (issueValid && !flush) begin
            r.rt  = issueRT;
            r.we  = issueWE;
            r.lat = (issueLatency > 4) ? 4 : int'(issueLatency);
            if (issueLatency > 4) m_err[3] = 1'b1;
            r.res = (issueLatency == 0) ? issueResult : '0;
            r.stg = 0;
            pipe.push_back(r);
        end
    endtask

    task automatic check_state();
        logic [6:0]   ert;
        logic         ewe;
        int           elat;
        logic [127:0] eres;
        for (int k = 0; k < 5; k++) begin
            ert = '0; ewe = 1'b0; elat = 0; eres = '0;
            foreach (pipe[i]) if (pipe[i].stg == k) begin
                ert = pipe[i].rt; ewe = pipe[i].we;
                elat = pipe[i].lat; eres = pipe[i].res;
            end
            chk($sformatf("stage_ST%0d", k + 3),
                d_rt[k] == ert && d_we[k] == ewe &&
                int'(d_lat[k]) == elat && d_res[k] == eres,
                $sformatf("got rt=%0d we=%0d lat=%0d res=%h want rt=%0d we=%0d lat=%0d res=%h",
                          d_rt[k], d_we[k], d_lat[k], d_res[k], ert, ewe, elat, eres));
        end
        chk("errFlags", errFlags == m_err,
            $sformatf("got %b want %b", errFlags, m_err));
        chk("retireCount", retireCount == m_ret,
            $sformatf("got %0d want %0d", retireCount, m_ret));
    endtask

    task automatic cyc(input bit iv, input logic [6:0] rt, input bit we,
                       input logic [2:0] lat, input logic [127:0] res,
                       input bit cv, input logic [127:0] cr, input bit fl);
        issueValid = iv; issueRT = rt; issueWE = we;
        issueLatency = lat; issueResult = res;
        compValid = cv; compResult = cr; flush = fl;
        model_edge();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string name);
        bit ok;
        ok = !wbValid && wbRT == 0 && wbResult == 0 &&
             errFlags == 0 && retireCount == 0;
        for (int k = 0; k < 5; k++)
            if (d_rt[k] != 0 || d_we[k] != 0 || d_lat[k] != 0 || d_res[k] != 0)
                ok = 1'b0;
        chk(name, ok, $sformatf("got wbValid=%0d wbRT=%0d err=%b ret=%0d rt3=%0d lat3=%0d want all zero",
                                wbValid, wbRT, errFlags, retireCount, rt3, lt3));
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        issueValid = 0; issueRT = 0; issueWE = 0; issueLatency = 0;
        issueResult = 0; compValid = 0; compResult = 0; flush = 0;
        pipe.delete();
        exp_q.delete();
        m_err = '0;
        m_ret = '0;
        #1;
        check_zero(name);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    wb_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wbValid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 1'b0,
                        $sformatf("got wbRT=%0d wbResult=%h want no writeback", wbRT, wbResult));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_data", wbRT == mon_e.rt && wbResult == mon_e.res,
                        $sformatf("got rt=%0d res=%h want rt=%0d res=%h",
                                  wbRT, wbResult, mon_e.rt, mon_e.res));
                end
            end else begin
                chk("wb_idle_zero", wbRT == 0 && wbResult == 0,
                    $sformatf("got rt=%0d res=%h want 0", wbRT, wbResult));
            end
        end
    end

    initial begin
        bit           iv, we, cv, fl;
        logic [2:0]   l;
        logic [127:0] r, c;

        do_reset("reset_initial");

        // simple L=0 writeback
        cyc(1, 5, 1, 0, 128'hAA, 0, 0, 0);
        idle(5);
        chk("s1_wb", wbValid && wbRT == 5 && wbResult == 128'hAA && retireCount == 1,
            $sformatf("got v=%0d rt=%0d res=%h ret=%0d want 1/5/aa/1",
                      wbValid, wbRT, wbResult, retireCount));

        // late completion on the ST5 entry
        do_reset("reset_s2");
        cyc(1, 9, 1, 3, 0, 0, 0, 0);
        idle(2);
        chk("s2_lat_st5", lt5 == 1, $sformatf("got %0d want 1", lt5));
        cyc(0, 0, 0, 0, 0, 1, 128'h55, 0);
        chk("s2_res_st6", rs6 == 128'h55 && lt6 == 0,
            $sformatf("got res=%h lat=%0d want 55/0", rs6, lt6));
        idle(2);
        chk("s2_wb", wbValid && wbResult == 128'h55 && errFlags == 0,
            $sformatf("got v=%0d res=%h err=%b want 1/55/0000", wbValid, wbResult, errFlags));

        // collision: older entry wins
        do_reset("reset_s3");
        cyc(1, 1, 1, 2, 0, 0, 0, 0);
        cyc(1, 2, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 128'h77, 0);
        chk("s3_collide", errFlags[2] && rs5 == 128'h77 && rs4 == 0,
            $sformatf("got err=%b st5=%h st4=%h want collide/77/0", errFlags, rs5, rs4));
        idle(4);

        // missing completion, then orphan
        do_reset("reset_s4");
        cyc(1, 3, 1, 2, 0, 0, 0, 0);
        idle(2);
        chk("s4_late", errFlags == 4'b0001, $sformatf("got %b want 0001", errFlags));
        idle(4);
        cyc(0, 0, 0, 0, 0, 1, 128'h1234, 0);
        chk("s4_orphan", errFlags == 4'b0011, $sformatf("got %b want 0011", errFlags));

        // flush with live entries
        do_reset("reset_s5");
        cyc(1, 8, 1, 0, 128'h8, 0, 0, 0);
        cyc(1, 9, 1, 0, 128'h9, 0, 0, 0);
        cyc(1, 10, 1, 0, 128'hA, 0, 0, 0);
        cyc(1, 11, 1, 0, 128'hB, 0, 0, 0);
        cyc(1, 12, 1, 0, 128'hC, 0, 0, 1);
        chk("s5_flush", !we4 && !we5 && rt3 == 0 && !we3 && we6 && we7,
            $sformatf("got we3..7=%0d%0d%0d%0d%0d rt3=%0d want 00011/0",
                      we3, we4, we5, we6, we7, rt3));
        idle(6);
        chk("s5_retired", retireCount == 2, $sformatf("got %0d want 2", retireCount));

        // illegal latency clamps; reset mid-flight
        do_reset("reset_s6");
        cyc(1, 4, 1, 6, 128'hF, 0, 0, 0);
        chk("s6_bad", lt3 == 4 && errFlags == 4'b1000,
            $sformatf("got lat=%0d err=%b want 4/1000", lt3, errFlags));
        cyc(1, 6, 1, 0, 128'hE, 0, 0, 0);
        #2;
        do_reset("reset_midflight");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                #2;
                do_reset("reset_random_mid");
            end
            iv = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) l = 3'($urandom_range(5, 7));
            else l = 3'($urandom_range(0, 4));
            r = {$urandom, $urandom, $urandom, $urandom};
            c = {$urandom, $urandom, $urandom, $urandom};
            if (has_hit()) cv = ($urandom_range(0, 9) != 0);
            else cv = ($urandom_range(0, 19) == 0);
            fl = ($urandom_range(0, 11) == 0);
            cyc(iv, 7'($urandom), we, l, r, cv, c, fl);
        end
        idle(8);
        @(negedge clk);
        #1;
        chk("drain", exp_q.size() == 0,
            $sformatf("got %0d pending writebacks want 0", exp_q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
